// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg
//   Shared types and helpers for the seven-segment display scheduler.
//   disp_state_e : display owner (live PC or a captured write event)
//   disp_msg_t   : captured write event payload (address low byte, data low half)
//   HEX7 / hex7  : active-low segment patterns, bit order {g,f,e,d,c,b,a}
package seg_disp_pkg;

   typedef enum logic {
      SHOW_PC = 1'b0,
      SHOW_EV = 1'b1
   } disp_state_e;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] wdata;
   } disp_msg_t;

   localparam logic [6:0] HEX7 [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      return HEX7[nib];
   endfunction

endpackage

// File: rtl/seg_disp_sched_fifo.sv
// disp_ev_fifo
//   First-word-fall-through FIFO holding pending display events.
//   Used by seg_disp_sched only when DISP_EV_QUEUE_EN is defined.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push, din     write an entry (caller guarantees !full)
//     pop, dout     consume head entry (caller guarantees !empty); dout is the head
//     full, empty   registered occupancy flags
module disp_ev_fifo
   import seg_disp_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  disp_msg_t din,
   input  logic      pop,
   output disp_msg_t dout,
   output logic      full,
   output logic      empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   disp_msg_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + 1'b1;
      end else if (pop && !push) begin
         count_nxt = count - 1'b1;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/seg_disp_sched.sv
// seg_disp_sched
//   Owns the 8-digit active-low seven-segment display and shares it between
//   the live program counter (default owner) and queued CPU memory-write
//   events. Each event is shown as EE<addr><wdata> for HOLD_FRAMES full scan
//   frames; ownership only changes at frame ends so frames are never torn.
//   Configuration macro: DISP_EV_QUEUE_EN
//     defined   -> pending store is a QDEPTH-entry FIFO (arrival order)
//     undefined -> pending store is a single register; QDEPTH unused
//   Ports:
//     CLK100MHZ   board clock
//     reset       asynchronous, active-high
//     pc_data     live PC, sampled per digit slot
//     ev_valid    write event offered
//     ev_ready    event accepted when ev_valid && ev_ready (registered !full)
//     ev_addr     write address low byte
//     ev_wdata    write data low half
//     seg         segments, active-low
//     an          digit enables, active-low one-hot
//     showing_ev  high while an event owns the display
//     drop_cnt    saturating count of ev_valid && !ev_ready cycles
module seg_disp_sched
   import seg_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV    = 262144,
   parameter int unsigned HOLD_FRAMES = 64,
   parameter int unsigned QDEPTH      = 4
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic [31:0] pc_data,
   input  logic        ev_valid,
   output logic        ev_ready,
   input  logic [7:0]  ev_addr,
   input  logic [15:0] ev_wdata,
   output logic [6:0]  seg,
   output logic [7:0]  an,
   output logic        showing_ev,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

   if (SCAN_DIV < 2 || HOLD_FRAMES < 1 || QDEPTH < 2 ||
       (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_params
      $error("seg_disp_sched: illegal parameter set");
   end

   logic [PW-1:0] presc;
   logic [2:0]    idx;
   logic          tick;
   logic          frame_end;

   disp_state_e   state;
   disp_state_e   state_nxt;
   disp_msg_t     cur;
   logic [HW-1:0] hold;
   logic [31:0]   word;

   disp_msg_t     in_msg;
   disp_msg_t     pend_msg;
   logic          pend_full;
   logic          pend_empty;
   logic          do_push;
   logic          do_pop;

   assign tick      = (presc == PW'(SCAN_DIV - 1));
   assign frame_end = tick && (idx == 3'd7);

   // ---------------- pending store ----------------
   assign in_msg   = {ev_addr, ev_wdata};
   assign ev_ready = ~pend_full;
   assign do_push  = ev_valid && ev_ready;

`ifdef DISP_EV_QUEUE_EN
   disp_ev_fifo #(
      .DEPTH(QDEPTH)
   ) u_fifo (
      .clk   (CLK100MHZ),
      .rst   (reset),
      .push  (do_push),
      .din   (in_msg),
      .pop   (do_pop),
      .dout  (pend_msg),
      .full  (pend_full),
      .empty (pend_empty)
   );
`else
   logic      slot_valid;
   disp_msg_t slot_msg;

   // Push needs an empty slot and pop needs a full one, so they never coincide.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         slot_valid <= 1'b0;
         slot_msg   <= '0;
      end else if (do_push) begin
         slot_valid <= 1'b1;
         slot_msg   <= in_msg;
      end else if (do_pop) begin
         slot_valid <= 1'b0;
      end
   end

   assign pend_msg   = slot_msg;
   assign pend_full  = slot_valid;
   assign pend_empty = ~slot_valid;
`endif

   // ---------------- ownership FSM ----------------
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         state      <= SHOW_PC;
         showing_ev <= 1'b0;
      end else begin
         state      <= state_nxt;
         showing_ev <= (state_nxt == SHOW_EV);
      end
   end

   always_comb begin
      state_nxt = state;
      do_pop    = 1'b0;
      if (frame_end) begin
         unique case (state)
            SHOW_PC: begin
               if (!pend_empty) begin
                  state_nxt = SHOW_EV;
                  do_pop    = 1'b1;
               end
            end
            SHOW_EV: begin
               if (hold == HW'(1)) begin
                  if (!pend_empty) begin
                     do_pop = 1'b1;
                  end else begin
                     state_nxt = SHOW_PC;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      word = pc_data;
      if (state == SHOW_EV) begin
         word = {8'hEE, cur.addr, cur.wdata};
      end
   end

   // Current event and its remaining frame count.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         cur  <= '0;
         hold <= '0;
      end else if (do_pop) begin
         cur  <= pend_msg;
         hold <= HW'(HOLD_FRAMES);
      end else if (frame_end && state == SHOW_EV) begin
         hold <= (hold > HW'(1)) ? hold - 1'b1 : '0;
      end
   end

   // ---------------- scan timing and digit drive ----------------
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         presc <= '0;
         idx   <= '0;
         an    <= '1;
         seg   <= '1;
      end else if (tick) begin
         presc <= '0;
         an    <= ~(8'b1 << idx);
         seg   <= hex7(word[4*idx +: 4]);
         idx   <= idx + 3'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (ev_valid && !ev_ready && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_seg_disp_sched.sv
`timescale 1ns/1ps
module tb_seg_disp_sched;

   localparam int unsigned SD    = 4;
   localparam int unsigned HF    = 2;
   localparam int unsigned QD    = 4;
   localparam int unsigned FRAME = 8 * SD;
`ifdef DISP_EV_QUEUE_EN
   localparam int unsigned CAP = QD;
`else
   localparam int unsigned CAP = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_data = '0;
   logic        ev_valid = 1'b0;
   logic [7:0]  ev_addr = '0;
   logic [15:0] ev_wdata = '0;
   logic        ev_ready;
   logic [6:0]  seg;
   logic [7:0]  an;
   logic        showing_ev;
   logic [7:0]  drop_cnt;

   seg_disp_sched #(
      .SCAN_DIV(SD),
      .HOLD_FRAMES(HF),
      .QDEPTH(QD)
   ) dut (
      .CLK100MHZ (clk),
      .reset     (rst),
      .pc_data   (pc_data),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_addr   (ev_addr),
      .ev_wdata  (ev_wdata),
      .seg       (seg),
      .an        (an),
      .showing_ev(showing_ev),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name, input string why);
      n_total++;
      $display("FAIL %s: %s (t=%0t)", name, why, $time);
   endtask

   // Active-low glyphs {g..a}, written out independently of the design.
   logic [6:0] font [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef struct packed { logic [7:0] a; logic [15:0] d; } ev_t;
   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       ready;
      logic       showing;
      logic [7:0] drop;
   } obs_t;

   // Reference model: cycle number since reset release decides scan timing.
   ev_t         pend[$];
   obs_t        exp_q[$];
   bit          m_own;
   ev_t         m_cur;
   int unsigned m_left;
   int unsigned m_drop;
   int unsigned m_cyc;
   logic [7:0]  m_an;
   logic [6:0]  m_seg;
   bit          mon_on = 1'b1;

   task automatic model_reset();
      pend.delete();
      exp_q.delete();
      m_own  = 0;
      m_left = 0;
      m_drop = 0;
      m_cyc  = 0;
      m_an   = 8'hFF;
      m_seg  = 7'h7F;
   endtask

   // Predicts the state after the next rising edge from the inputs now driven.
   task automatic model_step();
      bit          acc;
      int unsigned k, dg;
      logic [31:0] w;
      logic [3:0]  nib;
      obs_t        o;
      m_cyc++;
      acc = ev_valid && (pend.size() < CAP);
      if (ev_valid && !acc && m_drop < 255) m_drop++;
      if (m_cyc % SD == 0) begin
         k   = m_cyc / SD;
         dg  = (k - 1) % 8;
         w   = m_own ? {8'hEE, m_cur.a, m_cur.d} : pc_data;
         nib = w[4*dg +: 4];
         m_an  = ~(8'd1 << dg);
         m_seg = font[nib];
         if (dg == 7) begin
            if (m_own && m_left > 1) m_left--;
            else if (pend.size() > 0) begin
               m_cur  = pend.pop_front();
               m_own  = 1;
               m_left = HF;
            end else m_own = 0;
         end
      end
      if (acc) pend.push_back(ev_t'{ev_addr, ev_wdata});
      o.an      = m_an;
      o.seg     = m_seg;
      o.ready   = (pend.size() < CAP);
      o.showing = m_own;
      o.drop    = 8'(m_drop);
      exp_q.push_back(o);
   endtask

   task automatic cycle(input logic v, input logic [7:0] a, input logic [15:0] d,
                        input logic [31:0] pc);
      @(negedge clk);
      ev_valid = v;
      ev_addr  = a;
      ev_wdata = d;
      pc_data  = pc;
      model_step();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00, 16'h0000, pc_data);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_an"},    an,         8'hFF);
      check({tag, "_seg"},   seg,        7'h7F);
      check({tag, "_show"},  showing_ev, 1'b0);
      check({tag, "_drop"},  drop_cnt,   8'h00);
      check({tag, "_ready"}, ev_ready,   1'b1);
   endtask

   // Called at a falling edge with rst high; the next rising edge is cycle 1.
   task automatic release_reset(input logic [31:0] pc);
      ev_valid = 1'b0;
      pc_data  = pc;
      rst      = 1'b0;
      model_step();
   endtask

   // Monitor: every cycle the DUT presents an observation; compare to the head.
   always @(posedge clk) begin
      obs_t e;
      #1;
      if (!rst && mon_on) begin
         if (exp_q.size() == 0) fail_now("scoreboard", "no expected entry queued");
         else begin
            e = exp_q.pop_front();
            check("an",         an,         e.an);
            check("seg",        seg,        e.seg);
            check("ev_ready",   ev_ready,   e.ready);
            check("showing_ev", showing_ev, e.showing);
            check("drop_cnt",   drop_cnt,   e.drop);
         end
      end
   end

   initial begin
      int unsigned guard;

      // Power-on reset and first frames of the PC (digits 5, A, 0, ...).
      repeat (2) @(negedge clk);
      check_reset_state("por");
      model_reset();
      release_reset(32'h0000_00A5);
      idle(3 * FRAME);

      // One event mid-frame.
      while (m_cyc % FRAME != 10) idle(1);
      cycle(1'b1, 8'h54, 16'h0007, pc_data);
      idle(5 * FRAME);

      // Six back-to-back events right after a frame end.
      while (m_cyc % FRAME != 0) idle(1);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 16'($urandom), pc_data);
      idle(CAP * HF * FRAME + 3 * FRAME);

      // Random traffic with a changing PC.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 15) == 0, 8'($urandom), 16'($urandom), 32'($urandom));
      idle(2 * FRAME);

      // Reset in the second frame of an event with others queued.
      while (m_cyc % FRAME != 0) idle(1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 16'($urandom), pc_data);
      guard = 0;
      while (!(m_own && m_left == 1 && m_cyc % FRAME == 12) && guard < 600) begin
         idle(1);
         guard++;
      end
      if (guard >= 600) fail_now("reach_second_frame", "event second frame not reached");
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("midrst");
      model_reset();
      ev_valid = 1'b0;
      repeat (2) @(negedge clk);
      release_reset(32'h1234_5678);
      idle(4 * FRAME);

      // Saturation of the drop counter.
      for (int i = 0; i < 400; i++) cycle(1'b1, 8'($urandom), 16'($urandom), pc_data);
      @(posedge clk);
      #2;
      check("drop_saturated", drop_cnt, 8'hFF);
      idle(2 * FRAME);

      @(posedge clk);
      #2;
      mon_on = 1'b0;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
